dcache_wbuf: RTL

DCACHE_WBUF -- requirements
Module: dcache_wbuf

---
 rtl/dcache_wbuf.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/dcache_wbuf.sv
// Data-cache write buffer: a circular FIFO of posted writes with read forwarding,
// write coalescing, and an IDLE/DRAIN/READ memory sequencer.
module dcache_wbuf #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cache_req,
    input  logic                    cache_we,
    input  logic [ADDR_WIDTH-1:0]   cache_addr,
    input  logic [DATA_WIDTH-1:0]   cache_wdata,
    output logic                    cache_ready,
    output logic [DATA_WIDTH-1:0]   cache_rdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    wbuf_full,
    output logic                    wbuf_empty,
    output logic [$clog2(DEPTH):0]  wbuf_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [PW-1:0]         r_head;
    logic [PW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic [ADDR_WIDTH-1:0] r_rd_addr;

    logic                  w_hit;
    logic [PW-1:0]         w_hit_idx;
    logic [PW-1:0]         w_scan;
    logic                  w_full;
    logic                  w_is_write;
    logic                  w_is_read;
    logic                  w_coalesce;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rd_hit;
    logic                  w_rd_done;

    // Scan oldest to youngest so the last hit is the youngest matching entry.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_scan    = r_head;
        for (int k = 0; k < DEPTH; k++) begin
            w_scan = r_head + PW'(k);
            if (r_valid[w_scan] && (r_addr[w_scan] == cache_addr)) begin
                w_hit     = 1'b1;
                w_hit_idx = w_scan;
            end else begin
                w_hit     = w_hit;
                w_hit_idx = w_hit_idx;
            end
        end
    end

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_is_write = ~rst & cache_req & cache_we;
    assign w_is_read  = ~rst & cache_req & ~cache_we & (r_state != READ);
    // The head entry is on the memory bus during DRAIN, so it must not change under it.
    assign w_coalesce = w_is_write & w_hit & ~((r_state == DRAIN) && (w_hit_idx == r_head));
    assign w_push     = w_is_write & ~w_coalesce & ~w_full;
    assign w_pop      = (r_state == DRAIN) & mem_ready;
    assign w_rd_hit   = w_is_read & w_hit;
    assign w_rd_done  = (r_state == READ) & mem_ready;

    assign wbuf_count = r_count;
    assign wbuf_empty = (r_count == CW'(0));
    assign wbuf_full  = w_full;

    // Next-state and memory-side outputs.
    always_comb begin
        w_next_state = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        case (r_state)
            IDLE: begin
                if (w_is_read && !w_hit) begin
                    w_next_state = READ;
                end else if (r_count != CW'(0)) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            DRAIN: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = r_addr[r_head];
                mem_wdata = r_data[r_head];
                if (mem_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            READ: begin
                mem_req  = 1'b1;
                mem_addr = r_rd_addr;
                if (mem_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = READ;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Cache-side completion and read data.
    always_comb begin
        cache_ready = w_coalesce | w_push | w_rd_hit | w_rd_done;
        cache_rdata = '0;
        if (w_rd_hit) begin
            cache_rdata = r_data[w_hit_idx];
        end else if (w_rd_done) begin
            cache_rdata = mem_rdata;
        end else begin
            cache_rdata = '0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Miss address latched when leaving IDLE for READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_addr <= '0;
        end else if ((r_state == IDLE) && w_is_read && !w_hit) begin
            r_rd_addr <= cache_addr;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_addr[r_tail]  <= cache_addr;
                r_data[r_tail]  <= cache_wdata;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + PW'(1);
            end
            if (w_coalesce) begin
                r_data[w_hit_idx] <= cache_wdata;
            end
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
